posit_add_stream_raw: RTL and testbench

Parametrised, fully pipelined raw-posit adder/subtractor with valid/ready flow control. Consumes two serialized raw posit values (sign, scale, fraction, inf, zero flags), aligns, adds or subtracts, normalizes, and emits an unrounded sum with a sticky bit for a downstream rounding/encode stage. It generalises the fixed-width ES3 adder to any scale/fraction width. It also adds a per-operation subtract mode, exact-cancellation-to-zero handling, signed scale comparison, and back-pressure.

---
 rtl/posit_add_stream_raw.sv | 200 ++++++++++++++++++++
 tb/tb_posit_add_stream_raw.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_add_stream_raw.sv
// Pipelined raw-posit adder/subtractor: decode/compare, align/add, leading-zero count and
// normalize stages with valid/ready flow control; emits an unrounded sum plus sticky bit.
module posit_add_stream_raw #(
  parameter int unsigned FRAC_W  = 26,
  parameter int unsigned SCALE_W = 9,
  parameter int unsigned GUARD   = 3,
  parameter int unsigned IN_W    = 1 + SCALE_W + FRAC_W + 2,
  parameter int unsigned OUT_W   = 1 + (SCALE_W + 1) + (FRAC_W + GUARD) + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in1,
  input  logic [IN_W-1:0]  in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             sticky
);

  localparam int unsigned SIG_W = FRAC_W + GUARD + 1;
  localparam int unsigned OFR_W = FRAC_W + GUARD;
  localparam int unsigned OSC_W = SCALE_W + 1;
  localparam int unsigned LZ_W  = $clog2(SIG_W + 1);

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic               a_sgn, a_inf, a_zero, b_sgn_raw, b_sgn, b_inf, b_zero;
  logic [SCALE_W-1:0] a_scl, b_scl;
  logic [FRAC_W-1:0]  a_frc, b_frc;

  assign {a_sgn, a_scl, a_frc, a_inf, a_zero}     = in1;
  assign {b_sgn_raw, b_scl, b_frc, b_inf, b_zero} = in2;
  assign b_sgn = b_sgn_raw ^ sub;

  // A zero operand always loses the compare; ties go to in1.
  logic a_hi;
  always_comb begin
    if (b_zero)                     a_hi = 1'b1;
    else if (a_zero)                a_hi = 1'b0;
    else if (a_scl != b_scl)        a_hi = $signed(a_scl) > $signed(b_scl);
    else                            a_hi = a_frc >= b_frc;
  end

  logic               h_sgn, h_zero, l_sgn, l_zero;
  logic [SCALE_W-1:0] h_scl, l_scl;
  logic [FRAC_W-1:0]  h_frc, l_frc;
  logic [OSC_W-1:0]   diff_d;

  assign {h_sgn, h_scl, h_frc, h_zero} = a_hi ? {a_sgn, a_scl, a_frc, a_zero}
                                              : {b_sgn, b_scl, b_frc, b_zero};
  assign {l_sgn, l_scl, l_frc, l_zero} = a_hi ? {b_sgn, b_scl, b_frc, b_zero}
                                              : {a_sgn, a_scl, a_frc, a_zero};
  assign diff_d = l_zero ? '0 : {h_scl[SCALE_W-1], h_scl} - {l_scl[SCALE_W-1], l_scl};

  // Stage 1 registers
  logic               s1_valid_q, s1_h_sgn_q, s1_h_zero_q, s1_l_sgn_q, s1_l_zero_q, s1_inf_q;
  logic [SCALE_W-1:0] s1_h_scl_q;
  logic [FRAC_W-1:0]  s1_h_frc_q, s1_l_frc_q;
  logic [OSC_W-1:0]   s1_diff_q;

  logic [SIG_W-1:0]   hi_sig, lo_sig, aligned;
  logic [2*SIG_W-1:0] lo_ext;
  logic               align_stk;
  logic [SIG_W:0]     sum_d;

  always_comb begin
    hi_sig = s1_h_zero_q ? '0 : {1'b1, s1_h_frc_q, {GUARD{1'b0}}};
    lo_sig = s1_l_zero_q ? '0 : {1'b1, s1_l_frc_q, {GUARD{1'b0}}};
    lo_ext = '0;
    if (s1_diff_q >= OSC_W'(SIG_W)) begin
      aligned   = '0;
      align_stk = |lo_sig;
    end else begin
      lo_ext    = {lo_sig, {SIG_W{1'b0}}} >> s1_diff_q;
      aligned   = lo_ext[2*SIG_W-1:SIG_W];
      align_stk = |lo_ext[SIG_W-1:0];
    end
    if (s1_h_sgn_q == s1_l_sgn_q) sum_d = {1'b0, hi_sig} + {1'b0, aligned};
    else                          sum_d = {1'b0, hi_sig} - {1'b0, aligned};
  end

  // Stage 2 registers
  logic               s2_valid_q, s2_sgn_q, s2_stk_q, s2_inf_q;
  logic [SCALE_W-1:0] s2_scl_q;
  logic [SIG_W:0]     s2_sum_q;

  logic [LZ_W-1:0] lzc_d;
  logic            lz_found;
  always_comb begin
    lzc_d    = LZ_W'(SIG_W);
    lz_found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!lz_found && s2_sum_q[i]) begin
        lzc_d    = LZ_W'(SIG_W - 1 - i);
        lz_found = 1'b1;
      end
    end
  end

  // Stage 3 registers
  logic               s3_valid_q, s3_sgn_q, s3_stk_q, s3_inf_q;
  logic [SCALE_W-1:0] s3_scl_q;
  logic [SIG_W:0]     s3_sum_q;
  logic [LZ_W-1:0]    s3_lzc_q;

  logic [OSC_W-1:0] scl_ext, scl_o;
  logic [SIG_W-1:0] norm;
  logic [OFR_W-1:0] frc_o;
  logic             stk_o;
  logic [OUT_W-1:0] res_d;
  logic             stk_d;

  always_comb begin
    scl_ext = {s3_scl_q[SCALE_W-1], s3_scl_q};
    norm    = s3_sum_q[SIG_W-1:0] << s3_lzc_q;
    if (s3_sum_q[SIG_W]) begin
      frc_o = s3_sum_q[SIG_W-1:1];
      stk_o = s3_stk_q | s3_sum_q[0];
      scl_o = scl_ext + OSC_W'(1);
    end else begin
      frc_o = norm[SIG_W-2:0];
      stk_o = s3_stk_q;
      scl_o = scl_ext - {{(OSC_W - LZ_W){1'b0}}, s3_lzc_q};
    end
    res_d = '0;
    stk_d = 1'b0;
    if (s3_inf_q) begin
      res_d[1] = 1'b1;
    end else if (s3_sum_q == '0) begin
      res_d[0] = 1'b1;
    end else begin
      res_d = {s3_sgn_q, scl_o, frc_o, 2'b00};
      stk_d = stk_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_h_sgn_q  <= 1'b0;
      s1_h_zero_q <= 1'b0;
      s1_l_sgn_q  <= 1'b0;
      s1_l_zero_q <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_h_scl_q  <= '0;
      s1_h_frc_q  <= '0;
      s1_l_frc_q  <= '0;
      s1_diff_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_sgn_q    <= 1'b0;
      s2_stk_q    <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_scl_q    <= '0;
      s2_sum_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_sgn_q    <= 1'b0;
      s3_stk_q    <= 1'b0;
      s3_inf_q    <= 1'b0;
      s3_scl_q    <= '0;
      s3_sum_q    <= '0;
      s3_lzc_q    <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      sticky      <= 1'b0;
    end else if (en) begin
      s1_valid_q  <= in_valid;
      s1_h_sgn_q  <= h_sgn;
      s1_h_zero_q <= h_zero;
      s1_l_sgn_q  <= l_sgn;
      s1_l_zero_q <= l_zero;
      s1_inf_q    <= a_inf | b_inf;
      s1_h_scl_q  <= h_scl;
      s1_h_frc_q  <= h_frc;
      s1_l_frc_q  <= l_frc;
      s1_diff_q   <= diff_d;
      s2_valid_q  <= s1_valid_q;
      s2_sgn_q    <= s1_h_sgn_q;
      s2_stk_q    <= align_stk;
      s2_inf_q    <= s1_inf_q;
      s2_scl_q    <= s1_h_scl_q;
      s2_sum_q    <= sum_d;
      s3_valid_q  <= s2_valid_q;
      s3_sgn_q    <= s2_sgn_q;
      s3_stk_q    <= s2_stk_q;
      s3_inf_q    <= s2_inf_q;
      s3_scl_q    <= s2_scl_q;
      s3_sum_q    <= s2_sum_q;
      s3_lzc_q    <= lzc_d;
      out_valid   <= s3_valid_q;
      result      <= res_d;
      sticky      <= stk_d;
    end
  end

endmodule

// File: tb/tb_posit_add_stream_raw.sv
// Scoreboard bench for posit_add_stream_raw: directed vectors, back-pressured stream checked
// against an exact-arithmetic model, and mid-flight reset.
module tb_posit_add_stream_raw;

  localparam int FRAC_W  = 26;
  localparam int SCALE_W = 9;
  localparam int GUARD   = 3;
  localparam int IN_W    = 1 + SCALE_W + FRAC_W + 2;
  localparam int OFR_W   = FRAC_W + GUARD;
  localparam int OSC_W   = SCALE_W + 1;
  localparam int OUT_W   = 1 + OSC_W + OFR_W + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in1 = '0;
  logic [IN_W-1:0]  in2 = '0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] result;
  logic             sticky;

  posit_add_stream_raw #(
    .FRAC_W (FRAC_W),
    .SCALE_W(SCALE_W),
    .GUARD  (GUARD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .sticky   (sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OUT_W-1:0] res;
    logic             stk;
    int               issue;
    bit               chk_lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   bp_en = 1'b0;

  function automatic logic [IN_W-1:0] mk_in(bit s, int e, logic [FRAC_W-1:0] f, bit inf, bit z);
    return {s, SCALE_W'(e), f, inf, z};
  endfunction

  function automatic logic [OUT_W-1:0] mk_out(bit s, int e, logic [OFR_W-1:0] f, bit inf, bit z);
    return {s, OSC_W'(e), f, inf, z};
  endfunction

  // Exact model: both significands on a common grid, signed add, then renormalize.
  function automatic void model(input bit sa, input int ea, input logic [FRAC_W-1:0] fa,
                                input bit sb, input int eb, input logic [FRAC_W-1:0] fb,
                                output logic [OUT_W-1:0] r, output logic st);
    int     base, p, sc;
    longint va, vb, s, m, mask;
    logic [OFR_W-1:0] fr;
    base = (ea < eb) ? ea : eb;
    va = longint'({1'b1, fa}) << (ea - base);
    vb = longint'({1'b1, fb}) << (eb - base);
    if (sa) va = -va;
    if (sb) vb = -vb;
    s = va + vb;
    if (s == 0) begin
      r  = mk_out(0, 0, '0, 0, 1);
      st = 1'b0;
      return;
    end
    m = (s < 0) ? -s : s;
    p = 0;
    for (int i = 0; i < 63; i++) if (m[i]) p = i;
    sc = base + p - FRAC_W;
    if (p >= OFR_W) begin
      fr   = OFR_W'(m >> (p - OFR_W));
      mask = (longint'(1) << (p - OFR_W)) - 1;
      st   = (m & mask) != 0;
    end else begin
      fr = OFR_W'(m << (OFR_W - p));
      st = 1'b0;
    end
    r = mk_out(s < 0, sc, fr, 0, 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b, input bit s,
                       input logic [OUT_W-1:0] er, input logic es, input bit lat);
    bit   ok;
    int   icyc;
    exp_t e;
    in1 = a;
    in2 = b;
    sub = s;
    in_valid = 1'b1;
    ok = 1'b0;
    icyc = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok   = 1'b1;
        icyc = cyc;
      end
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles, required 1");
    end else begin
      e.res = er;
      e.stk = es;
      e.issue = icyc;
      e.chk_lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshake ordering, stall stability, in_ready tracking, latency.
  bit               was_stall = 1'b0;
  logic [OUT_W-1:0] held_res;
  logic             held_stk;
  exp_t             me;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        was_stall = 1'b0;
      end else begin
        if (out_valid) chk("in_ready_tracks_out_ready", 64'(in_ready), 64'(out_ready));
        if (was_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_result", 64'(result), 64'(held_res));
          chk("stall_sticky", 64'(sticky), 64'(held_stk));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: result %0h with no pending operation", result);
          end else begin
            me = q.pop_front();
            chk("result", 64'(result), 64'(me.res));
            chk("sticky", 64'(sticky), 64'(me.stk));
            if (me.chk_lat) chk("latency", 64'(cyc - me.issue), 64'd4);
          end
        end
        was_stall = out_valid && !out_ready;
        held_res  = result;
        held_stk  = sticky;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  logic [OUT_W-1:0] er;
  logic             es;
  bit               sa, sb, sbt;
  int               ea, eb;
  logic [FRAC_W-1:0] fa, fb;

  initial begin
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_sticky", 64'(sticky), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Directed vectors, back to back with out_ready held high.
    issue(mk_in(0, 0, '0, 0, 0), mk_in(0, 0, '0, 0, 0), 0, mk_out(0, 1, '0, 0, 0), 0, 1);
    issue(mk_in(0, 0, 26'h2000000, 0, 0), mk_in(1, -2, '0, 0, 0), 0,
          mk_out(0, 0, 29'h08000000, 0, 0), 0, 1);
    issue(mk_in(0, 0, '0, 0, 0), mk_in(0, 0, '0, 0, 0), 1, mk_out(0, 0, '0, 0, 1), 0, 1);
    issue(mk_in(0, 1, 26'h2000000, 0, 0), mk_in(0, 1, 26'h2000000, 0, 0), 1,
          mk_out(0, 0, '0, 0, 1), 0, 1);
    issue(mk_in(0, 0, '0, 0, 0), mk_in(0, -40, '0, 0, 0), 0, mk_out(0, 0, '0, 0, 0), 1, 1);
    issue(mk_in(0, 3, 26'h1234, 1, 0), mk_in(0, 0, '0, 0, 0), 0, mk_out(0, 0, '0, 1, 0), 0, 1);
    issue(mk_in(1, 5, 26'h123, 0, 1), mk_in(1, 2, 26'h2000000, 0, 0), 0,
          mk_out(1, 2, 29'h10000000, 0, 0), 0, 1);
    issue(mk_in(0, 0, '0, 0, 0), mk_in(0, 0, 26'h2000000, 0, 0), 1,
          mk_out(1, -1, '0, 0, 0), 0, 1);
    issue(mk_in(1, 7, 26'h55, 0, 1), mk_in(0, -3, 26'h99, 0, 1), 0,
          mk_out(0, 0, '0, 0, 1), 0, 1);
    issue(mk_in(0, -1, '0, 0, 0), mk_in(0, 1, '0, 0, 0), 0,
          mk_out(0, 1, 29'h08000000, 0, 0), 0, 1);
    issue(mk_in(0, 0, 26'h3FFFFFF, 0, 0), mk_in(0, -3, 26'h1, 0, 0), 0,
          mk_out(0, 1, 29'h01FFFFFC, 0, 0), 1, 1);
    drain();

    // Back-pressured stream against the exact model.
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sa  = 1'($urandom);
      sb  = 1'($urandom);
      sbt = 1'($urandom);
      ea  = int'($urandom_range(8, 0)) - 4;
      eb  = ea + int'($urandom_range(6, 0)) - 3;
      fa  = FRAC_W'($urandom);
      fb  = FRAC_W'($urandom);
      if (i == 3) begin
        eb  = ea;
        fb  = fa;
        sb  = sa;
        sbt = 1'b1;
      end
      model(sa, ea, fa, sb ^ sbt, eb, fb, er, es);
      issue(mk_in(sa, ea, fa, 0, 0), mk_in(sb, eb, fb, 0, 0), sbt, er, es, 0);
    end
    drain();
    bp_en = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);

    // Reset with operations in flight and the output stalled.
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(mk_in(0, 0, '0, 0, 0), mk_in(0, 0, '0, 0, 0), 0, mk_out(0, 1, '0, 0, 0), 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_output", 64'(out_valid), 64'd0);
    issue(mk_in(0, 0, '0, 0, 0), mk_in(0, 0, '0, 0, 0), 0, mk_out(0, 1, '0, 0, 0), 0, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
